// File: rtl/regfile_wb_arbiter_if.sv
// Producer-to-write-back handshake channel: one result beat per valid&ready.
// master = producing stage, slave = write-back arbiter.
interface regfile_wb_arbiter_if;
    logic        valid;
    logic        ready;
    logic [2:0]  addr;
    logic [31:0] data;

    modport master (
        output valid,
        output addr,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  data,
        output ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: ALU and ID FIFOs feeding the single register-file write port.
// Optional WB_BYPASS_EN: lone beat into an idle arbiter skips its FIFO.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    regfile_wb_arbiter_if.slave        alu_i,
    regfile_wb_arbiter_if.slave        id_i,
    output logic                       w_enable_o,
    output logic                       w_select_o,
    output logic [2:0]                 w_addr_o,
    output logic [31:0]                w_alu_o,
    output logic [31:0]                w_id_o,
    output logic [7:0]                 pend_mask_o,
    output logic                       idle_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Source index 0 = ALU, 1 = ID throughout.
    logic [1:0]    valid;
    logic [1:0]    ready;
    logic [1:0]    push;
    logic [1:0]    wr;
    logic [1:0]    pop;
    logic [1:0]    nonempty;
    logic [2:0]    in_addr [2];
    logic [31:0]   in_data [2];
    logic [2:0]    head_addr [2];
    logic [31:0]   head_data [2];

    logic [2:0]    addr_q [2][DEPTH];
    logic [31:0]   data_q [2][DEPTH];
    logic [PW-1:0] wptr_q [2];
    logic [PW-1:0] wptr_d [2];
    logic [PW-1:0] rptr_q [2];
    logic [PW-1:0] rptr_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];

    logic          last_grant_q;
    logic          last_grant_d;
    logic          w_enable_q;
    logic          w_enable_d;
    logic          w_select_q;
    logic          w_select_d;
    logic [2:0]    w_addr_q;
    logic [2:0]    w_addr_d;
    logic [31:0]   w_alu_q;
    logic [31:0]   w_alu_d;
    logic [31:0]   w_id_q;
    logic [31:0]   w_id_d;

    logic          grant_v;
    logic          grant_id;
    logic          bypass;
    logic [2:0]    sel_addr;
    logic [31:0]   sel_data;
    logic [PW-1:0] off;
    logic [7:0]    pm;

    assign valid      = {id_i.valid, alu_i.valid};
    assign in_addr[0] = alu_i.addr;
    assign in_addr[1] = id_i.addr;
    assign in_data[0] = alu_i.data;
    assign in_data[1] = id_i.data;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            ready[s]     = (cnt_q[s] < CW'(DEPTH)) && rst_n;
            push[s]      = valid[s] && ready[s];
            nonempty[s]  = (cnt_q[s] != '0);
            head_addr[s] = addr_q[s][rptr_q[s]];
            head_data[s] = data_q[s][rptr_q[s]];
        end
    end

    assign alu_i.ready = ready[0];
    assign id_i.ready  = ready[1];

    // Same-address heads always favour ALU: it holds the older instruction.
    always_comb begin
        grant_v  = 1'b0;
        grant_id = 1'b0;
        bypass   = 1'b0;
        if (nonempty[0] && nonempty[1]) begin
            grant_v  = 1'b1;
            grant_id = (head_addr[0] != head_addr[1]) && !last_grant_q;
        end else if (nonempty[0]) begin
            grant_v  = 1'b1;
            grant_id = 1'b0;
        end else if (nonempty[1]) begin
            grant_v  = 1'b1;
            grant_id = 1'b1;
        end
`ifdef WB_BYPASS_EN
        else if (push[0] ^ push[1]) begin
            grant_v  = 1'b1;
            grant_id = push[1];
            bypass   = 1'b1;
        end
`endif
    end

    always_comb begin
        pop[0]   = grant_v && !grant_id && !bypass;
        pop[1]   = grant_v && grant_id && !bypass;
        wr[0]    = push[0] && !(bypass && !grant_id);
        wr[1]    = push[1] && !(bypass && grant_id);
        sel_addr = bypass ? in_addr[grant_id] : head_addr[grant_id];
        sel_data = bypass ? in_data[grant_id] : head_data[grant_id];
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            cnt_d[s]  = cnt_q[s] + CW'(wr[s]) - CW'(pop[s]);
            wptr_d[s] = wptr_q[s] + PW'(wr[s]);
            rptr_d[s] = rptr_q[s] + PW'(pop[s]);
        end
        last_grant_d = grant_v ? grant_id : last_grant_q;
        w_enable_d   = grant_v;
        w_select_d   = grant_v && grant_id;
        w_addr_d     = grant_v ? sel_addr : 3'd0;
        w_alu_d      = (grant_v && !grant_id) ? sel_data : 32'd0;
        w_id_d       = (grant_v && grant_id) ? sel_data : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                cnt_q[s]  <= '0;
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
            end
            last_grant_q <= 1'b1;
            w_enable_q   <= 1'b0;
            w_select_q   <= 1'b0;
            w_addr_q     <= 3'd0;
            w_alu_q      <= 32'd0;
            w_id_q       <= 32'd0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                cnt_q[s]  <= cnt_d[s];
                wptr_q[s] <= wptr_d[s];
                rptr_q[s] <= rptr_d[s];
            end
            last_grant_q <= last_grant_d;
            w_enable_q   <= w_enable_d;
            w_select_q   <= w_select_d;
            w_addr_q     <= w_addr_d;
            w_alu_q      <= w_alu_d;
            w_id_q       <= w_id_d;
        end
    end

    // Storage needs no reset: only entries inside the count are ever read.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (wr[s]) begin
                addr_q[s][wptr_q[s]] <= in_addr[s];
                data_q[s][wptr_q[s]] <= in_data[s];
            end
        end
    end

    always_comb begin
        pm  = 8'd0;
        off = '0;
        for (int s = 0; s < 2; s++) begin
            for (int j = 0; j < DEPTH; j++) begin
                off = PW'(j) - rptr_q[s];
                if ({1'b0, off} < cnt_q[s]) begin
                    pm[addr_q[s][j]] = 1'b1;
                end
            end
        end
        if (w_enable_q) begin
            pm[w_addr_q] = 1'b1;
        end
    end

    assign pend_mask_o = pm;
    assign idle_o      = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !w_enable_q;
    assign w_enable_o  = w_enable_q;
    assign w_select_o  = w_select_q;
    assign w_addr_o    = w_addr_q;
    assign w_alu_o     = w_alu_q;
    assign w_id_o      = w_id_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a per-edge reference of both
// queues and the arbiter predicts every write and the visible status outputs.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    typedef struct {
        logic        sel;
        logic [2:0]  addr;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        w_enable;
    logic        w_select;
    logic [2:0]  w_addr;
    logic [31:0] w_alu;
    logic [31:0] w_id;
    logic [7:0]  pend_mask;
    logic        idle;

    regfile_wb_arbiter_if alu_if ();
    regfile_wb_arbiter_if id_if ();

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_i       (alu_if.slave),
        .id_i        (id_if.slave),
        .w_enable_o  (w_enable),
        .w_select_o  (w_select),
        .w_addr_o    (w_addr),
        .w_alu_o     (w_alu),
        .w_id_o      (w_id),
        .pend_mask_o (pend_mask),
        .idle_o      (idle)
    );

    int n_checks = 0;
    int n_fail   = 0;

    ent_t        qa[$];
    ent_t        qi[$];
    ent_t        outq[$];
    logic        lg = 1'b1;
    logic [31:0] rf [8];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: check the current cycle, then advance the model across the next edge.
    initial begin
        ent_t e;
        logic [7:0] m;
        logic acc_a;
        logic acc_i;
        @(posedge clk);
        forever begin
            @(negedge clk);
            m = 8'd0;
            foreach (qa[k]) m[qa[k].addr] = 1'b1;
            foreach (qi[k]) m[qi[k].addr] = 1'b1;
            if (outq.size() > 0) m[outq[0].addr] = 1'b1;
            check("alu_ready", alu_if.ready, rst_n && (qa.size() < DEPTH));
            check("id_ready", id_if.ready, rst_n && (qi.size() < DEPTH));
            check("pend_mask", pend_mask, m);
            check("idle", idle, (qa.size() == 0) && (qi.size() == 0) && (outq.size() == 0));
            check("w_enable", w_enable, outq.size() != 0);
            if (w_enable) begin
                rf[w_addr] = w_select ? w_id : w_alu;
                if (outq.size() > 0) begin
                    e = outq.pop_front();
                    check("w_select", w_select, e.sel);
                    check("w_addr", w_addr, e.addr);
                    check("w_data", e.sel ? w_id : w_alu, e.data);
                    check("w_other", e.sel ? w_alu : w_id, 0);
                end
            end else begin
                check("idle_bus", {w_select, w_addr, w_alu, w_id}, 0);
            end
            if (!rst_n) begin
                qa.delete();
                qi.delete();
                lg = 1'b1;
            end else begin
                acc_a = alu_if.valid && (qa.size() < DEPTH);
                acc_i = id_if.valid && (qi.size() < DEPTH);
                if (qa.size() > 0 && qi.size() > 0) begin
                    if (qa[0].addr == qi[0].addr || lg) begin
                        outq.push_back(qa.pop_front());
                        lg = 1'b0;
                    end else begin
                        outq.push_back(qi.pop_front());
                        lg = 1'b1;
                    end
                end else if (qa.size() > 0) begin
                    outq.push_back(qa.pop_front());
                    lg = 1'b0;
                end else if (qi.size() > 0) begin
                    outq.push_back(qi.pop_front());
                    lg = 1'b1;
                end
`ifdef WB_BYPASS_EN
                else if (acc_a != acc_i) begin
                    e.sel = acc_i;
                    e.addr = acc_i ? id_if.addr : alu_if.addr;
                    e.data = acc_i ? id_if.data : alu_if.data;
                    outq.push_back(e);
                    lg = acc_i;
                    acc_a = 1'b0;
                    acc_i = 1'b0;
                end
`endif
                if (acc_a) begin
                    e.sel = 1'b0; e.addr = alu_if.addr; e.data = alu_if.data;
                    qa.push_back(e);
                end
                if (acc_i) begin
                    e.sel = 1'b1; e.addr = id_if.addr; e.data = id_if.data;
                    qi.push_back(e);
                end
            end
        end
    end

    task automatic drive(input logic av, input logic [2:0] aa, input logic [31:0] ad,
                         input logic iv, input logic [2:0] ia, input logic [31:0] id);
        alu_if.valid = av; alu_if.addr = aa; alu_if.data = ad;
        id_if.valid  = iv; id_if.addr  = ia; id_if.data  = id;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int c = 0;
        while ((qa.size() + qi.size() + outq.size()) != 0 && c < 40) begin
            drive(0, 0, 0, 0, 0, 0);
            c++;
        end
        check("drain", c < 40, 1);
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int na;
        int cyc;
        logic acc;
        foreach (rf[k]) rf[k] = 32'd0;
        rst_n = 1'b0;
        alu_if.valid = 1'b1; alu_if.addr = 3'd6; alu_if.data = 32'h1234;
        id_if.valid  = 1'b1; id_if.addr  = 3'd7; id_if.data  = 32'h5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_idle", idle, 1);
        check("rst_wen", w_enable, 0);
        check("rst_ready", {alu_if.ready, id_if.ready}, 0);
        alu_if.valid = 1'b0; id_if.valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_ready", {alu_if.ready, id_if.ready}, 2'b11);

        drive(1, 3, 32'hDEADBEEF, 0, 0, 0);
        drain();
        check("rf3", rf[3], 32'hDEADBEEF);

        for (int i = 0; i < 8; i++)
            drive(1, 1, 32'h100 + i, 1, 2, 32'h200 + i);
        drain();

        drive(1, 5, 32'h11, 1, 5, 32'h22);
        drain();
        check("rf5", rf[5], 32'h22);

        na = 0;
        cyc = 0;
        while (na < 6 && cyc < 60) begin
            alu_if.valid = 1'b1;
            alu_if.addr  = 3'(4 + na % 3);
            alu_if.data  = 32'hA000 + na;
            id_if.valid  = 1'b1;
            id_if.addr   = 3'd7;
            id_if.data   = 32'hB000 + cyc;
            @(negedge clk);
            acc = alu_if.ready;
            @(posedge clk);
            #1;
            if (acc) na++;
            cyc++;
        end
        check("bp_beats", na, 6);
        drain();

        for (int i = 0; i < 4; i++)
            drive(1, 1, 32'hC00 + i, 1, 2, 32'hD00 + i);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_wen", w_enable, 0);
        check("mr_pend", pend_mask, 0);
        check("mr_idle", idle, 1);
        @(posedge clk); #1;
        drain();
        repeat (3) drive(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that drives the single write port of the 8×32 register file from two producers: the ALU stage and the ID stage. Each producer hands results over with a valid/ready handshake into its own small FIFO. The block issues at most one register write per cycle as registered `w_enable`/`w_select`/`w_addr`/`w_alu`/`w_id` outputs. It also publishes a pending-write mask for hazard detection.

## Interface
- `DEPTH`, default 2: entries per source FIFO; power of two, ≥2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `alu_valid`  in  1  ALU result offered.
- `alu_ready`  out  1  ALU FIFO can accept.
- `alu_addr`  in  3  destination register.
- `alu_data`  in  32  result value.
- `id_valid`, `id_ready`, `id_addr`, `id_data`: same as the ALU group, for the ID stage.
- `w_enable`  out  1  register-file write strobe.
- `w_select`  out  1  0 = ALU data, 1 = ID data.
- `w_addr`  out  3  write address.
- `w_alu`  out  32  ALU write data; 0 when not selected.
- `w_id`  out  32  ID write data; 0 when not selected.
- `pend_mask`  out  8  bit r set while any queued or issued-not-committed write targets register r.
- `idle`  out  1  both FIFOs empty and `w_enable`=0.

## Operation
- **Accept.** A beat is accepted on a rising edge with `x_valid && x_ready`.
  - `x_ready` = (FIFO count < DEPTH) and `rst_n`=1.
  - `x_ready` depends on state only; there is no combinational pop-through when full.
- **Issue.** Each cycle at most one FIFO head is popped and loaded into the output register.
  - Only one source non-empty: that source issues.
  - Both non-empty, different addresses: round-robin on a `last_grant` flag. After reset `last_grant` = ID, so the first conflict goes to ALU.
  - Both non-empty, same address: ALU issues first, because it holds the older instruction. `last_grant` is updated normally.
- **Output register.**
  - On issue: `w_enable`=1, `w_select` = source, `w_addr` = entry address, selected data bus = entry data, other data bus = 0.
  - No issue: `w_enable`=0, `w_select`=0, `w_addr`=0, both data buses 0.
- **pend_mask.** OR of one-hot decodes of every valid FIFO entry address plus `w_addr` when `w_enable`=1. Derived combinationally from state only.
- **Ordering.** FIFO order is preserved within a source. Cross-source order is only as defined above.
- **Reset.** `rst_n`=0 at an edge has the following effect:
  - Empties both FIFOs, discarding pending writes.
  - Clears the output register, so no write is issued in the following cycle.
  - Sets `last_grant` to ID.
  - Reset values: `w_enable`=0, `w_select`=0, `w_addr`=0, `w_alu`=0, `w_id`=0, `pend_mask`=0, `idle`=1, `alu_ready`=`id_ready`=0 while `rst_n`=0, then 1.

## Timing
- **Base latency.** A beat accepted at edge k issues at the earliest at edge k+1. `w_enable` is high in cycle k+1→k+2, and the register file commits at edge k+2.
- **Throughput.** One write per cycle in aggregate. A single source streaming alone sustains one beat per cycle at DEPTH≥2.
- **Simultaneous events.**
  - Push and pop of the same FIFO on one edge leave the count unchanged.
  - Push into a full FIFO cannot occur because ready is 0.
- **Starvation bound.** A non-empty source waits at most 1 cycle under different-address contention. Under same-address contention it waits until the ALU head moves on.
- **Pointers.** Wrap modulo DEPTH. Count width is log2(DEPTH)+1.

## Configuration
- `WB_BYPASS_EN` defined: a beat accepted at edge k is loaded straight into the output register at edge k, skipping its FIFO, when all of the following hold:
  - its FIFO is empty;
  - the other FIFO is empty;
  - the other source is not accepting a beat on the same edge.
  - In that case `w_enable` is high in cycle k→k+1 and the register file commits at edge k+1.
  - `pend_mask` covers the bypassed beat through the output register.
- `WB_BYPASS_EN` undefined: every beat passes through its FIFO; base latency always applies.

## Test plan
- **Reset.** Hold `rst_n`=0 for 2 edges with both valids high → outputs all 0, readies 0, `idle`=1. On release, readies go to 1.
- **Single ALU write.** `alu_addr`=3, `alu_data`=0xDEADBEEF for one cycle → one cycle later `w_enable`=1, `w_select`=0, `w_addr`=3, `w_alu`=0xDEADBEEF, `w_id`=0; `pend_mask`=0x08 until then. With `WB_BYPASS_EN`, the output appears one cycle earlier.
- **Contention, different addresses.** Both valid every cycle, ALU→r1, ID→r2 → issues alternate ALU, ID, ALU…, starting with ALU; each producer sees ready drop once its FIFO holds DEPTH entries.
- **Same-address conflict.** ALU→r5=0x11 and ID→r5=0x22 accepted on the same edge → ALU write issues first, ID write the next cycle; final r5=0x22.
- **Backpressure.** ALU streams 6 beats with DEPTH=2 while ID competes → `alu_ready` never high when count=2; all 6 writes emerge in order, none lost or duplicated.
- **Mid-operation reset.** Both FIFOs full, assert `rst_n`=0 for one edge → next cycle `w_enable`=0, `pend_mask`=0, `idle`=1; none of the discarded writes appear afterwards.
